riscv_wb_driver: RTL and testbench

Regression-bench stimulus block that drives the integer register-file writeback interface (valid, we, addr, data), the same interface sampled by the register checkers. The bench loads write commands into a small FIFO; the driver replays them onto the writeback bus with a programmable per-command idle gap. This lets checker and regfile-side logic be exercised without a full core. Simulation and regression only; not synthesised into the MPSoC.

---
 rtl/riscv_mpsoc_pkg.sv | 23 ++
 rtl/riscv_wb_cmd_fifo.sv | 60 ++++++
 rtl/riscv_wb_driver.sv | 146 ++++++++++++++
 tb/tb_riscv_wb_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mpsoc_pkg.sv
// Shared types for the MPSoC regression stimulus blocks: register-file
// writeback driver state encoding and the buffered command payload.
package riscv_mpsoc_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned WB_DEPTH   = 8;
  localparam int unsigned GAP_W      = 4;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_GAP   = 2'd1,
    WB_ISSUE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic [GAP_W-1:0]      gap;
  } wb_cmd_t;

endpackage

// File: rtl/riscv_wb_cmd_fifo.sv
// Synchronous command FIFO for the writeback driver. Registered empty/full
// and occupancy count; exposes the head entry and the gap of the entry behind
// it so the driver can chain beats without a bubble.
module riscv_wb_cmd_fifo
  import riscv_mpsoc_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_cmd_t          wdata,
  output wb_cmd_t          head_c,
  output logic [GAP_W-1:0] second_gap_c,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [CNT_W-1:0] count_n;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign do_push      = push && !full;
  assign do_pop       = pop && !empty;
  assign count_n      = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign rd_ptr_p1    = rd_ptr + PTR_W'(1);
  assign head_c       = mem[rd_ptr];
  assign second_gap_c = mem[rd_ptr_p1].gap;

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr_p1;
      count <= count_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_wb_driver.sv
// Regression stimulus: replays buffered write commands onto the integer
// register-file writeback bus with a per-command idle gap.
// Optional build macro RISCV_WB_DRIVER_X0_FILTER_EN: writes to x0 still
// produce a counted beat but with wb_we forced low.
module riscv_wb_driver
  import riscv_mpsoc_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [REG_ADDR_W-1:0] cmd_addr,
  input  logic [XLEN-1:0]       cmd_data,
  input  logic [GAP_W-1:0]      cmd_gap,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic                  busy,
  output logic [15:0]           issued_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_state_e             state_q;
  wb_state_e             state_n;
  logic [GAP_W-1:0]      gap_q;
  logic [GAP_W-1:0]      gap_n;
  wb_cmd_t               cmd_in;
  wb_cmd_t               head;
  logic [GAP_W-1:0]      second_gap;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      fifo_count_n;
  logic                  push_c;
  logic                  pop_c;
  logic                  head_we_c;
  logic                  wb_valid_n;
  logic                  wb_we_n;
  logic [REG_ADDR_W-1:0] wb_addr_n;
  logic [XLEN-1:0]       wb_data_n;

  assign push_c       = cmd_valid && cmd_ready;
  assign cmd_in       = '{we: cmd_we, addr: cmd_addr, data: cmd_data, gap: cmd_gap};
  assign fifo_count_n = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);

`ifdef RISCV_WB_DRIVER_X0_FILTER_EN
  assign head_we_c = head.we && (head.addr != '0);
`else
  assign head_we_c = head.we;
`endif

  riscv_wb_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push_c),
    .pop          (pop_c),
    .wdata        (cmd_in),
    .head_c       (head),
    .second_gap_c (second_gap),
    .empty        (fifo_empty),
    .count        (fifo_count)
  );

  // FSM state and gap countdown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_n;
      gap_q   <= gap_n;
    end
  end

  // Next-state, FIFO pop and next writeback beat; the follow-on command is
  // judged from the pre-pop count, so a push into the last slot waits in IDLE.
  always_comb begin
    state_n    = state_q;
    gap_n      = gap_q;
    pop_c      = 1'b0;
    wb_valid_n = 1'b0;
    wb_we_n    = 1'b0;
    wb_addr_n  = wb_addr;
    wb_data_n  = wb_data;
    case (state_q)
      WB_IDLE: begin
        if (!fifo_empty) begin
          if (head.gap == '0) begin
            state_n = WB_ISSUE;
          end else begin
            state_n = WB_GAP;
            gap_n   = head.gap;
          end
        end
      end
      WB_GAP: begin
        gap_n = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) state_n = WB_ISSUE;
      end
      WB_ISSUE: begin
        pop_c      = 1'b1;
        wb_valid_n = 1'b1;
        wb_we_n    = head_we_c;
        wb_addr_n  = head.addr;
        wb_data_n  = head.data;
        if (fifo_count < CNT_W'(2)) begin
          state_n = WB_IDLE;
        end else if (second_gap == '0) begin
          state_n = WB_ISSUE;
        end else begin
          state_n = WB_GAP;
          gap_n   = second_gap;
        end
      end
      default: state_n = WB_IDLE;
    endcase
  end

  // Registered writeback bus, status flags and saturating beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      issued_cnt <= '0;
    end else begin
      wb_valid  <= wb_valid_n;
      wb_we     <= wb_we_n;
      wb_addr   <= wb_addr_n;
      wb_data   <= wb_data_n;
      busy      <= (fifo_count_n != '0) || (state_n != WB_IDLE);
      cmd_ready <= (fifo_count_n != CNT_W'(DEPTH));
      if (wb_valid_n && (issued_cnt != 16'hFFFF)) issued_cnt <= issued_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_riscv_wb_driver.sv
// Scoreboard bench for riscv_wb_driver. Each accepted command gets its beat
// cycle predicted from the previous beat: a command already queued when its
// predecessor issues follows it after 1+gap cycles, otherwise it issues
// 2+gap cycles after its own push.
module tb_riscv_wb_driver;

  localparam int DEPTH = 8;

  typedef struct {
    int          t;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic [3:0]  cmd_gap = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        busy;
  logic [15:0] issued_cnt;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          started = 1'b0;

  exp_t        sb[$];
  int          pend[$];
  int          last_t = -1000;
  logic [4:0]  last_addr = '0;
  logic [63:0] last_data = '0;
  logic [15:0] issued_m = '0;
  exp_t        mon_e;

  riscv_wb_driver dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_gap    (cmd_gap),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic flush();
    sb.delete();
    pend.delete();
    last_t    = -1000;
    last_addr = '0;
    last_data = '0;
    issued_m  = '0;
    started   = 1'b1;
  endtask

  // One bench cycle: check ready/busy against the model, then drive inputs.
  task automatic step(input logic r, input logic v, input logic we,
                      input logic [4:0] a, input logic [63:0] d, input logic [3:0] g);
    int   occ;
    int   p;
    exp_t e;
    @(negedge clk);
    #1;
    while (pend.size() > 0 && pend[0] <= cyc) void'(pend.pop_front());
    occ = pend.size();
    if (started) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(occ < DEPTH));
      chk("busy", 64'(busy), 64'(occ > 0));
    end
    rst       = r;
    cmd_valid = v;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_gap   = g;
    if (r) begin
      flush();
    end else if (v && occ < DEPTH) begin
      p      = cyc + 1;
      e.t    = (p < last_t) ? last_t + 1 + int'(g) : p + 2 + int'(g);
      last_t = e.t;
`ifdef RISCV_WB_DRIVER_X0_FILTER_EN
      e.we   = we && (a != 5'd0);
`else
      e.we   = we;
`endif
      e.addr = a;
      e.data = d;
      pend.push_back(e.t);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 4'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) idle(1);
    chk("drain_pending", 64'(sb.size()), 64'd0);
    idle(3);
  endtask

  // Monitor: every output beat must match the oldest predicted beat.
  always @(negedge clk) begin
    if (started) begin
      if (sb.size() > 0 && sb[0].t < cyc) begin
        checks++;
        errors++;
        $display("FAIL beat_missing cycle %0d got none expected beat at %0d", cyc, sb[0].t);
        void'(sb.pop_front());
      end
      if (wb_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat cycle %0d got addr %0d expected no beat", cyc, wb_addr);
        end else begin
          mon_e = sb.pop_front();
          if (issued_m != 16'hFFFF) issued_m = issued_m + 16'd1;
          chk("beat_cycle", 64'(cyc), 64'(mon_e.t));
          chk("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_we", 64'(wb_we), 64'(mon_e.we));
          chk("issued_cnt", 64'(issued_cnt), 64'(issued_m));
          last_addr = mon_e.addr;
          last_data = mon_e.data;
        end
      end else begin
        chk("idle_we", 64'(wb_we), 64'd0);
        chk("hold_addr", 64'(wb_addr), 64'(last_addr));
        chk("hold_data", wb_data, last_data);
        chk("idle_issued_cnt", 64'(issued_cnt), 64'(issued_m));
      end
    end
  end

  initial begin
    logic [3:0] g;
    // Reset
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 4'd0);
    idle(2);

    // Single gap-0 write
    step(1'b0, 1'b1, 1'b1, 5'd3, 64'hDEAD_BEEF, 4'd0);
    idle(5);
    chk("single_issued", 64'(issued_cnt), 64'd1);

    // Three back-to-back gap-0 writes
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, 5'(i), {$urandom, $urandom}, 4'd0);
    idle(6);

    // Gap of five idle cycles
    step(1'b0, 1'b1, 1'b1, 5'd7, {$urandom, $urandom}, 4'd5);
    idle(10);

    // Overfill behind gap-15 heads
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 5'(i + 8), {$urandom, $urandom}, 4'd15);
    drain();

    // Reset while queued and counting down a gap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 5'(i + 20), {$urandom, $urandom}, 4'd15);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 4'd0);
    idle(25);
    chk("post_reset_issued", 64'(issued_cnt), 64'd0);

    // Write to x0
    step(1'b0, 1'b1, 1'b1, 5'd0, 64'h1234_5678_9ABC_DEF0, 4'd0);
    idle(5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      g = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0)
        step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 4'd0);
      else
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), {$urandom, $urandom}, g);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
